raster_scheduler: RTL and testbench
===================================

# raster_scheduler

Frame-level sequencer for the triangle rasterizer. It queues triangle descriptors written by the MicroBlaze and clears the framebuffer at the start of each frame. It then launches the rasterizer once per queued triangle using the start/done handshake, and reports frame completion. It owns the framebuffer write port: during clear it drives the port itself, and otherwise it passes the rasterizer's write port through unchanged.

## Interface

- DEPTH, 4: triangle descriptor FIFO depth (power of two, ≥2)
- FB_WORDS, 76800: framebuffer words cleared per frame (320×240)
- CLEAR_COLOR, 8'h00: value written to every framebuffer word during clear

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- tri_valid  in  1  MicroBlaze presents a descriptor
- tri_ready  out  1  FIFO not full; push occurs when tri_valid && tri_ready
- tri_desc  in  230  packed descriptor, MSB→LSB: inv_area[32], color[8], a1,b1,a2,b2,a3,b3[9 each], c1,c2,c3[18 each], bbxi[9], bbxf[9], bbyi[8], bbyf[8], z1,z2,z3[16 each]
- frame_start  in  1  pulse: begin a frame (clear, then rasterize)
- frame_end  in  1  pulse: no further triangles for this frame
- rast_desc  out  230  registered descriptor to the rasterizer; stable from launch until done
- rasterizer_start  out  1  one-cycle launch pulse
- rasterizer_done  in  1  one-cycle completion pulse from the rasterizer
- rast_we, rast_din[8], rast_addr[17]  in  rasterizer framebuffer write port
- fb_we  out  1; fb_din  out  8; fb_addr  out  17  framebuffer write port
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when the frame is complete
- tri_count  out  16  triangles completed in the current frame
- queue_level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation

- FSM states: IDLE, CLEAR, WAIT_TRI, LAUNCH, RASTER, DONE.
- IDLE
  - frame_start → CLEAR; clr_addr←0, tri_count←0.
  - frame_end is ignored in IDLE, including when it arrives in the same cycle as frame_start.
- CLEAR
  - Each cycle: fb_we=1, fb_addr=clr_addr, fb_din=CLEAR_COLOR; clr_addr++.
  - After writing FB_WORDS-1 → WAIT_TRI.
  - The rasterizer port is ignored in CLEAR.
- WAIT_TRI
  - If the FIFO is non-empty: pop the head into rast_desc → LAUNCH.
  - Else if end_seen: → DONE.
  - Else stay.
- LAUNCH: rasterizer_start=1 for this one cycle → RASTER.
- RASTER: on rasterizer_done, tri_count++ → WAIT_TRI.
- DONE: frame_done=1 for one cycle; end_seen←0 → IDLE.
- end_seen
  - Sticky flag, set by frame_end in any state except IDLE.
  - Cleared in DONE and by reset.
- frame_start outside IDLE is ignored.
- FIFO
  - Pushes are accepted in every state, including IDLE and CLEAR.
  - Queued triangles wait until the clear finishes.
  - tri_ready = (level != DEPTH), so a push is refused when full even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves the level unchanged.
  - Pointers wrap modulo DEPTH.
- Write-port mux: in CLEAR the scheduler drives fb_*; in all other states fb_* = rast_* combinationally.
- rasterizer_done outside RASTER is ignored.
- tri_count saturates at 16'hFFFF.

## Timing

- Reset (rst_n=0 at a clock edge):
  - State IDLE; FIFO emptied; end_seen=0.
  - busy, frame_done, rasterizer_start = 0; tri_count, queue_level, rast_desc = 0.
  - tri_ready=1 in the first cycle after reset.
- Reset during CLEAR or RASTER abandons the operation. No start pulse is emitted after reset.
- Clear duration: exactly FB_WORDS cycles with fb_we=1, at addresses 0..FB_WORDS-1 in order, with no gaps.
- Push-to-visible: a descriptor pushed at edge N is poppable at edge N+1.
- WAIT_TRI pop at edge N: rast_desc is valid after N, and rasterizer_start is high during cycle N+1.
- rasterizer_done sampled at edge M:
  - The next rasterizer_start is high during cycle M+2 if the FIFO is non-empty.
  - Otherwise frame_done is high during cycle M+2 if end_seen=1.
- With an empty queue and end_seen already set on entering WAIT_TRI, frame_done follows one cycle later.
- rast_desc changes only on a pop.

## Test plan

- Reset mid-CLEAR (FB_WORDS=16, rst_n low at clear word 5) → next cycle: fb_we=0, busy=0, queue_level=0, tri_ready=1; no further clear writes.
- FB_WORDS=16, CLEAR_COLOR=8'hAA, frame_start with an empty queue, then frame_end → exactly 16 writes of 8'hAA at addresses 0..15, then frame_done 2 cycles after the clear ends, tri_count=0.
- Push 3 descriptors during IDLE, then frame_start and frame_end; the bench model answers each start with done 10 cycles later → 3 start pulses in FIFO order with matching rast_desc, each start 2 cycles after the previous done, tri_count=3, one frame_done pulse.
- DEPTH=4, hold tri_valid high with a stalled rasterizer → tri_ready drops after 4 pushes, and the 5th is accepted only after a pop; no descriptor is lost or duplicated.
- frame_start, and frame_end in the same cycle while in IDLE → clear runs, frame_end is ignored, no frame_done until a later frame_end.
- Outside CLEAR, rast_we=1, rast_addr=17'd1234, rast_din=8'h3C → same values appear on fb_* in the same cycle; a spurious rasterizer_done in WAIT_TRI does not change tri_count.

Source files
------------

// File: rtl/raster_scheduler_if.sv
// Bundles the raster_scheduler's descriptor queue, frame control, rasterizer
// handshake and framebuffer write port into a single bus.
interface raster_scheduler_if #(
    parameter int DEPTH = 4
);
    logic                       tri_valid;
    logic                       tri_ready;
    logic [229:0]               tri_desc;
    logic                       frame_start;
    logic                       frame_end;
    logic [229:0]               rast_desc;
    logic                       rasterizer_start;
    logic                       rasterizer_done;
    logic                       rast_we;
    logic [7:0]                 rast_din;
    logic [16:0]                rast_addr;
    logic                       fb_we;
    logic [7:0]                 fb_din;
    logic [16:0]                fb_addr;
    logic                       busy;
    logic                       frame_done;
    logic [15:0]                tri_count;
    logic [$clog2(DEPTH):0]     queue_level;

    // The scheduler side
    modport slave (
        input  tri_valid, tri_desc, frame_start, frame_end, rasterizer_done,
               rast_we, rast_din, rast_addr,
        output tri_ready, rast_desc, rasterizer_start, fb_we, fb_din, fb_addr,
               busy, frame_done, tri_count, queue_level
    );

    // The MicroBlaze / rasterizer / framebuffer side
    modport master (
        output tri_valid, tri_desc, frame_start, frame_end, rasterizer_done,
               rast_we, rast_din, rast_addr,
        input  tri_ready, rast_desc, rasterizer_start, fb_we, fb_din, fb_addr,
               busy, frame_done, tri_count, queue_level
    );
endinterface

// File: rtl/raster_scheduler.sv
// Frame sequencer: queues triangle descriptors, clears the framebuffer, then
// launches the rasterizer once per queued triangle and signals frame completion.
module raster_scheduler #(
    parameter int         DEPTH       = 4,
    parameter int         FB_WORDS    = 76800,
    parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    raster_scheduler_if.slave  bus
);
    localparam int              PW         = $clog2(DEPTH);
    localparam int              LW         = PW + 1;
    localparam logic [16:0]     LAST_ADDR  = 17'(FB_WORDS - 1);
    localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_TRI,
        LAUNCH,
        RASTER,
        DONE
    } state_t;

    state_t         state;
    logic [229:0]   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic [16:0]    clr_addr;
    logic           end_seen;
    logic [15:0]    tri_count;
    logic [229:0]   rast_desc;
    logic           start_q;
    logic           frame_done_q;
    logic           push;
    logic           pop;

    // Readiness looks only at the current level, so a full queue refuses a
    // push even in the cycle it is being popped.
    assign push = bus.tri_valid && (level != FULL_LEVEL);
    assign pop  = (state == WAIT_TRI) && (level != '0);

    assign bus.tri_ready        = (level != FULL_LEVEL);
    assign bus.queue_level      = level;
    assign bus.busy             = (state != IDLE);
    assign bus.tri_count        = tri_count;
    assign bus.rast_desc        = rast_desc;
    assign bus.rasterizer_start = start_q;
    assign bus.frame_done       = frame_done_q;

    assign bus.fb_we   = (state == CLEAR) ? 1'b1        : bus.rast_we;
    assign bus.fb_addr = (state == CLEAR) ? clr_addr    : bus.rast_addr;
    assign bus.fb_din  = (state == CLEAR) ? CLEAR_COLOR : bus.rast_din;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.tri_desc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            clr_addr     <= '0;
            end_seen     <= 1'b0;
            tri_count    <= '0;
            rast_desc    <= '0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.frame_end && (state != IDLE)) begin
                end_seen <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        state     <= CLEAR;
                        clr_addr  <= '0;
                        tri_count <= '0;
                    end
                end
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) begin
                        state <= WAIT_TRI;
                    end
                end
                WAIT_TRI: begin
                    if (level != '0) begin
                        rast_desc <= mem[rd_ptr];
                        start_q   <= 1'b1;
                        state     <= LAUNCH;
                    end else if (end_seen) begin
                        frame_done_q <= 1'b1;
                        state        <= DONE;
                    end
                end
                LAUNCH: begin
                    state <= RASTER;
                end
                RASTER: begin
                    if (bus.rasterizer_done) begin
                        if (tri_count != 16'hFFFF) begin
                            tri_count <= tri_count + 1'b1;
                        end
                        state <= WAIT_TRI;
                    end
                end
                DONE: begin
                    // Clearing here wins over a frame_end landing in DONE.
                    end_seen <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_raster_scheduler.sv
// Directed bench for raster_scheduler with a small framebuffer (16 words) and
// a behavioural rasterizer that answers each start with a done pulse.
module tb_raster_scheduler;
    localparam int         DEPTH    = 4;
    localparam int         FB_WORDS = 16;
    localparam logic [7:0] CLR      = 8'hAA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic model_done = 1'b0;
    logic spurious_done = 1'b0;
    logic model_mode = 1'b1;
    logic pending = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;

    logic [16:0]  wr_addr_q[$];
    logic [7:0]   wr_din_q[$];
    int           wr_cyc_q[$];
    logic [229:0] st_desc_q[$];
    int           st_cyc_q[$];
    int           done_cyc_q[$];

    raster_scheduler_if #(.DEPTH(DEPTH)) bus();

    raster_scheduler #(
        .DEPTH(DEPTH),
        .FB_WORDS(FB_WORDS),
        .CLEAR_COLOR(CLR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    assign bus.rasterizer_done = model_done | spurious_done;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Negedge monitor: cyc here equals the number of rising edges so far
    always @(negedge clk) begin
        if (bus.fb_we) begin
            wr_addr_q.push_back(bus.fb_addr);
            wr_din_q.push_back(bus.fb_din);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.rasterizer_start) begin
            st_desc_q.push_back(bus.rast_desc);
            st_cyc_q.push_back(cyc);
        end
        if (bus.rasterizer_done) done_cyc_q.push_back(cyc);
        if (bus.frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
        end
    end

    // Rasterizer model; a start seen while stalled is answered once released
    initial begin
        forever begin
            @(posedge clk); #1;
            if (bus.rasterizer_start) pending = 1'b1;
            if (pending && model_mode) begin
                pending = 1'b0;
                repeat (10) @(posedge clk);
                #1 model_done = 1'b1;
                @(posedge clk);
                #1 model_done = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [229:0] make_desc(input int k);
        return {32'hA5A5_0000 | 32'(k), 8'(k * 3 + 1), 190'(k * 7 + 5)};
    endfunction

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic pulse_frame_start;
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
    endtask

    task automatic pulse_frame_end;
        bus.frame_end = 1'b1;
        step();
        bus.frame_end = 1'b0;
    endtask

    task automatic wait_frame_done(input int base, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (fd_cnt > base) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
        total++; if (bus.rasterizer_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_start: got %b expected 0", bus.rasterizer_start); end
        total++; if (bus.tri_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_tri_count: got %0d expected 0", bus.tri_count); end
        total++; if (bus.queue_level !== 3'd0) begin bad++; $display("[TB] FAIL reset_level: got %0d expected 0", bus.queue_level); end
        total++; if (bus.rast_desc !== 230'd0) begin bad++; $display("[TB] FAIL reset_rast_desc: got %h expected 0", bus.rast_desc); end
        total++; if (bus.fb_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_fb_we: got %b expected 0", bus.fb_we); end
        rst_n = 1'b1;
        step();
        total++; if (bus.tri_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_tri_ready: got %b expected 1", bus.tri_ready); end
    endtask

    task automatic test_reset_mid_clear;
        int base_w;
        int base_st;
        bus.tri_valid = 1'b1;
        bus.tri_desc  = make_desc(1);
        step();
        bus.tri_valid = 1'b0;
        total++; if (bus.queue_level !== 3'd1) begin bad++; $display("[TB] FAIL midclr_level_pre: got %0d expected 1", bus.queue_level); end
        pulse_frame_start();
        total++; if (bus.fb_we !== 1'b1 || bus.fb_addr !== 17'd0) begin bad++; $display("[TB] FAIL midclr_word0: got we=%b addr=%0d expected we=1 addr=0", bus.fb_we, bus.fb_addr); end
        repeat (5) step();
        total++; if (bus.fb_addr !== 17'd5 || bus.fb_din !== CLR) begin bad++; $display("[TB] FAIL midclr_word5: got addr=%0d din=%h expected addr=5 din=%h", bus.fb_addr, bus.fb_din, CLR); end
        rst_n = 1'b0;
        step();
        total++; if (bus.fb_we !== 1'b0) begin bad++; $display("[TB] FAIL midclr_fb_we: got %b expected 0", bus.fb_we); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL midclr_busy: got %b expected 0", bus.busy); end
        total++; if (bus.queue_level !== 3'd0) begin bad++; $display("[TB] FAIL midclr_level: got %0d expected 0", bus.queue_level); end
        total++; if (bus.tri_ready !== 1'b1) begin bad++; $display("[TB] FAIL midclr_tri_ready: got %b expected 1", bus.tri_ready); end
        rst_n   = 1'b1;
        base_w  = wr_addr_q.size();
        base_st = st_desc_q.size();
        repeat (20) step();
        total++; if (wr_addr_q.size() != base_w) begin bad++; $display("[TB] FAIL midclr_no_writes: got %0d writes expected 0", wr_addr_q.size() - base_w); end
        total++; if (st_desc_q.size() != base_st) begin bad++; $display("[TB] FAIL midclr_no_start: got %0d starts expected 0", st_desc_q.size() - base_st); end
    endtask

    task automatic test_clear_empty;
        int base_w;
        int base_fd;
        bit ok;
        base_w  = wr_addr_q.size();
        base_fd = fd_cnt;
        pulse_frame_start();
        pulse_frame_end();
        wait_frame_done(base_fd, 60, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL clear_frame_done_seen: got none expected pulse"); end
        repeat (3) step();
        total++; if (wr_addr_q.size() - base_w != FB_WORDS) begin bad++; $display("[TB] FAIL clear_write_count: got %0d expected %0d", wr_addr_q.size() - base_w, FB_WORDS); end
        if (wr_addr_q.size() - base_w == FB_WORDS) begin
            for (int i = 0; i < FB_WORDS; i++) begin
                total++;
                if (wr_addr_q[base_w + i] !== 17'(i) || wr_din_q[base_w + i] !== CLR) begin
                    bad++;
                    $display("[TB] FAIL clear_word: got addr=%0d din=%h expected addr=%0d din=%h", wr_addr_q[base_w + i], wr_din_q[base_w + i], i, CLR);
                end
            end
            total++; if (wr_cyc_q[base_w + FB_WORDS - 1] - wr_cyc_q[base_w] != FB_WORDS - 1) begin bad++; $display("[TB] FAIL clear_no_gaps: got span %0d expected %0d", wr_cyc_q[base_w + FB_WORDS - 1] - wr_cyc_q[base_w], FB_WORDS - 1); end
            total++; if (fd_cyc - wr_cyc_q[base_w + FB_WORDS - 1] != 2) begin bad++; $display("[TB] FAIL clear_done_latency: got %0d expected 2", fd_cyc - wr_cyc_q[base_w + FB_WORDS - 1]); end
        end
        total++; if (bus.tri_count !== 16'd0) begin bad++; $display("[TB] FAIL clear_tri_count: got %0d expected 0", bus.tri_count); end
        total++; if (fd_cnt - base_fd != 1) begin bad++; $display("[TB] FAIL clear_done_pulses: got %0d expected 1", fd_cnt - base_fd); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL clear_idle_after: got busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_three_triangles;
        int base_st;
        int base_dn;
        int base_fd;
        bit ok;
        model_mode = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bus.tri_valid = 1'b1;
            bus.tri_desc  = make_desc(k);
            step();
        end
        bus.tri_valid = 1'b0;
        total++; if (bus.queue_level !== 3'd3) begin bad++; $display("[TB] FAIL three_level: got %0d expected 3", bus.queue_level); end
        base_st = st_desc_q.size();
        base_dn = done_cyc_q.size();
        base_fd = fd_cnt;
        pulse_frame_start();
        pulse_frame_end();
        wait_frame_done(base_fd, 200, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL three_frame_done_seen: got none expected pulse"); end
        repeat (2) step();
        total++; if (st_desc_q.size() - base_st != 3) begin bad++; $display("[TB] FAIL three_start_count: got %0d expected 3", st_desc_q.size() - base_st); end
        total++; if (done_cyc_q.size() - base_dn != 3) begin bad++; $display("[TB] FAIL three_done_count: got %0d expected 3", done_cyc_q.size() - base_dn); end
        if (st_desc_q.size() - base_st == 3 && done_cyc_q.size() - base_dn == 3) begin
            for (int i = 0; i < 3; i++) begin
                total++; if (st_desc_q[base_st + i] !== make_desc(i + 1)) begin bad++; $display("[TB] FAIL three_desc: got %h expected %h", st_desc_q[base_st + i], make_desc(i + 1)); end
            end
            for (int i = 1; i < 3; i++) begin
                total++; if (st_cyc_q[base_st + i] - done_cyc_q[base_dn + i - 1] != 2) begin bad++; $display("[TB] FAIL three_restart_gap: got %0d expected 2", st_cyc_q[base_st + i] - done_cyc_q[base_dn + i - 1]); end
            end
            total++; if (fd_cyc - done_cyc_q[base_dn + 2] != 2) begin bad++; $display("[TB] FAIL three_done_gap: got %0d expected 2", fd_cyc - done_cyc_q[base_dn + 2]); end
        end
        total++; if (bus.tri_count !== 16'd3) begin bad++; $display("[TB] FAIL three_tri_count: got %0d expected 3", bus.tri_count); end
        total++; if (fd_cnt - base_fd != 1) begin bad++; $display("[TB] FAIL three_done_pulses: got %0d expected 1", fd_cnt - base_fd); end
    endtask

    task automatic test_back_to_back;
        int  pushes;
        int  base_st;
        int  base_fd;
        int  st_at_accept;
        bit  rdy;
        bit  accepted;
        bit  ok;
        model_mode    = 1'b0;
        base_st       = st_desc_q.size();
        pushes        = 0;
        bus.tri_valid = 1'b1;
        bus.tri_desc  = make_desc(10);
        for (int i = 0; i < 10 && pushes < 4; i++) begin
            rdy = bus.tri_ready;
            step();
            if (rdy) begin
                pushes++;
                bus.tri_desc = make_desc(10 + pushes);
            end
        end
        total++; if (bus.tri_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_tri_ready: got %b expected 0", bus.tri_ready); end
        total++; if (bus.queue_level !== 3'd4) begin bad++; $display("[TB] FAIL full_level: got %0d expected 4", bus.queue_level); end
        repeat (3) step();
        total++; if (bus.queue_level !== 3'd4) begin bad++; $display("[TB] FAIL full_refused: got level %0d expected 4", bus.queue_level); end
        pulse_frame_start();
        accepted     = 1'b0;
        st_at_accept = 0;
        for (int i = 0; i < 60; i++) begin
            rdy = bus.tri_ready;
            step();
            if (rdy) begin
                accepted      = 1'b1;
                st_at_accept  = st_desc_q.size() - base_st;
                bus.tri_valid = 1'b0;
                break;
            end
        end
        bus.tri_valid = 1'b0;
        total++; if (!accepted) begin bad++; $display("[TB] FAIL fifth_accepted: got no push expected one after pop"); end
        total++; if (st_at_accept != 1) begin bad++; $display("[TB] FAIL fifth_after_pop: got %0d starts expected 1", st_at_accept); end
        total++; if (bus.queue_level !== 3'd4) begin bad++; $display("[TB] FAIL fifth_level: got %0d expected 4", bus.queue_level); end
        base_fd    = fd_cnt;
        model_mode = 1'b1;
        pulse_frame_end();
        wait_frame_done(base_fd, 400, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL b2b_frame_done_seen: got none expected pulse"); end
        total++; if (st_desc_q.size() - base_st != 5) begin bad++; $display("[TB] FAIL b2b_start_count: got %0d expected 5", st_desc_q.size() - base_st); end
        if (st_desc_q.size() - base_st == 5) begin
            for (int i = 0; i < 5; i++) begin
                total++; if (st_desc_q[base_st + i] !== make_desc(10 + i)) begin bad++; $display("[TB] FAIL b2b_desc: got %h expected %h", st_desc_q[base_st + i], make_desc(10 + i)); end
            end
        end
        total++; if (bus.tri_count !== 16'd5) begin bad++; $display("[TB] FAIL b2b_tri_count: got %0d expected 5", bus.tri_count); end
    endtask

    task automatic test_same_cycle;
        int base_w;
        int base_fd;
        bit ok;
        repeat (2) step();
        base_w          = wr_addr_q.size();
        base_fd         = fd_cnt;
        bus.frame_start = 1'b1;
        bus.frame_end   = 1'b1;
        step();
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        repeat (25) step();
        total++; if (fd_cnt != base_fd) begin bad++; $display("[TB] FAIL same_no_done: got %0d pulses expected 0", fd_cnt - base_fd); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL same_busy: got %b expected 1", bus.busy); end
        total++; if (wr_addr_q.size() - base_w != FB_WORDS) begin bad++; $display("[TB] FAIL same_clear_ran: got %0d writes expected %0d", wr_addr_q.size() - base_w, FB_WORDS); end
        pulse_frame_end();
        wait_frame_done(base_fd, 20, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL same_late_done: got none expected pulse"); end
        step();
        total++; if (fd_cnt - base_fd != 1) begin bad++; $display("[TB] FAIL same_done_pulses: got %0d expected 1", fd_cnt - base_fd); end
    endtask

    task automatic test_passthrough;
        int base_st;
        int base_fd;
        bit ok;
        bus.rast_we   = 1'b1;
        bus.rast_addr = 17'd1234;
        bus.rast_din  = 8'h3C;
        #1;
        total++; if (bus.fb_we !== 1'b1 || bus.fb_addr !== 17'd1234 || bus.fb_din !== 8'h3C) begin bad++; $display("[TB] FAIL pass_idle: got we=%b addr=%0d din=%h expected we=1 addr=1234 din=3c", bus.fb_we, bus.fb_addr, bus.fb_din); end
        pulse_frame_start();
        total++; if (bus.fb_addr !== 17'd0 || bus.fb_din !== CLR) begin bad++; $display("[TB] FAIL pass_clear_owns: got addr=%0d din=%h expected addr=0 din=%h", bus.fb_addr, bus.fb_din, CLR); end
        repeat (18) step();
        bus.rast_we   = 1'b0;
        bus.rast_addr = 17'h1FFFF;
        bus.rast_din  = 8'h5A;
        #1;
        total++; if (bus.fb_we !== 1'b0 || bus.fb_addr !== 17'h1FFFF || bus.fb_din !== 8'h5A) begin bad++; $display("[TB] FAIL pass_wait: got we=%b addr=%h din=%h expected we=0 addr=1ffff din=5a", bus.fb_we, bus.fb_addr, bus.fb_din); end
        base_st       = st_desc_q.size();
        spurious_done = 1'b1;
        step();
        spurious_done = 1'b0;
        repeat (3) step();
        total++; if (bus.tri_count !== 16'd0) begin bad++; $display("[TB] FAIL spurious_count: got %0d expected 0", bus.tri_count); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL spurious_busy: got %b expected 1", bus.busy); end
        total++; if (st_desc_q.size() != base_st) begin bad++; $display("[TB] FAIL spurious_start: got %0d starts expected 0", st_desc_q.size() - base_st); end
        bus.rast_addr = '0;
        bus.rast_din  = '0;
        base_fd       = fd_cnt;
        pulse_frame_end();
        wait_frame_done(base_fd, 20, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL pass_frame_done: got none expected pulse"); end
    endtask

    initial begin
        bus.tri_valid   = 1'b0;
        bus.tri_desc    = '0;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.rast_we     = 1'b0;
        bus.rast_din    = '0;
        bus.rast_addr   = '0;
        test_reset();
        test_reset_mid_clear();
        test_clear_empty();
        test_three_triangles();
        test_back_to_back();
        test_same_cycle();
        test_passthrough();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
